// File: rtl/rv_lsu.sv
// RV64 load/store unit driving a 64-bit doubleword memory port; sub-doubleword stores use read-modify-write.
// Optional misalignment rejection is compiled in with RV_LSU_MISALIGN_CHK_EN.
module rv_lsu_lane #(
  parameter int VEC_W = 8
) (
  input  logic             sel,
  input  logic [VEC_W-1:0] rd,
  input  logic [VEC_W-1:0] wr,
  output logic [VEC_W-1:0] q
);
  assign q = sel ? wr : rd;
endmodule

module rv_lsu #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [63:0]       mem_wr_data,
  output logic              mem_rd_en,
  input  logic [63:0]       mem_rd_data
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;

  typedef enum logic [2:0] {IDLE, LD_RD, LD_CAP, ST_RD, ST_MRG, ST_WR} state_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [2:0]  off;
    logic [63:0] wdata;
  } req_t;

  state_t state;
  req_t   rq;

  logic [2:0] acc_off;
  logic       acc_bad;
  logic       unused_addr;

  assign unused_addr = ^{req_addr[ADDR_W-1:MEM_AW+3]};
  assign req_ready   = rst_n && (state == IDLE);

  // Offset is forced to natural alignment; the check build rejects instead.
  always_comb begin
    acc_bad = 1'b0;
    acc_off = req_addr[2:0];
    unique case (req_funct3[1:0])
      2'd0: acc_off = req_addr[2:0];
      2'd1: begin
        acc_off = {req_addr[2:1], 1'b0};
`ifdef RV_LSU_MISALIGN_CHK_EN
        acc_bad = req_addr[0];
`endif
      end
      2'd2: begin
        acc_off = {req_addr[2], 2'b00};
`ifdef RV_LSU_MISALIGN_CHK_EN
        acc_bad = |req_addr[1:0];
`endif
      end
      default: begin
        acc_off = 3'd0;
`ifdef RV_LSU_MISALIGN_CHK_EN
        acc_bad = |req_addr[2:0];
`endif
      end
    endcase
  end

  // Load lane extraction and extension
  logic [63:0] rsh, ld_data;
  assign rsh = mem_rd_data >> {rq.off, 3'b000};

  always_comb begin
    ld_data = rsh;
    unique case (rq.funct3[1:0])
      2'd0: ld_data = rq.funct3[2] ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}},  rsh[7:0]};
      2'd1: ld_data = rq.funct3[2] ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
      2'd2: ld_data = rq.funct3[2] ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
      default: ld_data = rsh;
    endcase
  end

  // Store merge: per-byte lane mux between read data and shifted store data
  logic [3:0] lane_lo, lane_hi;
  logic [NUM_LANES-1:0]            lane_sel;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes, wr_lanes, mrg_lanes;

  assign lane_lo  = {1'b0, rq.off};
  assign lane_hi  = lane_lo + (4'd1 << rq.funct3[1:0]);
  assign rd_lanes = mem_rd_data;
  assign wr_lanes = rq.wdata << {rq.off, 3'b000};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sel
    assign lane_sel[i] = (4'(i) >= lane_lo) && (4'(i) < lane_hi);
  end

  rv_lsu_lane #(.VEC_W(VEC_W)) u_lane [NUM_LANES-1:0] (
    .sel (lane_sel),
    .rd  (rd_lanes),
    .wr  (wr_lanes),
    .q   (mrg_lanes)
  );

`ifdef RV_LSU_MISALIGN_CHK_EN
  logic err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rq          <= '0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
`ifdef RV_LSU_MISALIGN_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      resp_valid <= 1'b0;
`ifdef RV_LSU_MISALIGN_CHK_EN
      err_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid && acc_bad) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
`ifdef RV_LSU_MISALIGN_CHK_EN
            err_q      <= 1'b1;
`endif
          end else if (req_valid) begin
            rq       <= '{funct3: req_funct3, off: acc_off, wdata: req_wdata};
            mem_addr <= req_addr[MEM_AW+2:3];
            if (!req_we) begin
              state     <= LD_RD;
              mem_rd_en <= 1'b1;
            end else if (req_funct3[1:0] == 2'b11) begin
              state       <= ST_WR;
              mem_wr_en   <= 1'b1;
              mem_wr_data <= req_wdata;
            end else begin
              state     <= ST_RD;
              mem_rd_en <= 1'b1;
            end
          end
        end
        LD_RD:  state <= LD_CAP;
        LD_CAP: begin
          resp_rdata <= ld_data;
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        ST_RD:  state <= ST_MRG;
        ST_MRG: begin
          mem_wr_data <= mrg_lanes;
          mem_wr_en   <= 1'b1;
          state       <= ST_WR;
        end
        ST_WR: begin
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
